// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, optional parity bit when UART_RX_PARITY_EN is defined
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  // Full-bit and half-bit terminal counts; the half count centres sampling in each bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
`ifdef UART_RX_PARITY_EN
  logic             par_mis_q, par_mis_d;
`endif

  // Synchroniser stages: sync1 is metastability catch, rxd_s the usable line, rxd_d its one-cycle delay.
  logic             sync1_q;
  logic             rxd_s_q;
  logic             rxd_d_q;

  // Two-flop synchroniser plus edge-detect delay; reset high so a released reset never looks like a start edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_d_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      rxd_s_q <= sync1_q;
      rxd_d_q <= rxd_s_q;
    end
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      par_mis_q    <= par_mis_d;
`endif
    end
  end

  // Frame sequencing: start validation at mid start bit, then one sample per bit period.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis_d    = par_mis_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rxd_d_q && !rxd_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          // A line already back high at mid start bit was a glitch, not a frame.
          state_d   = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rxd_s_q;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          par_mis_d = (rxd_s_q != ((^shift_q) ^ PAR_ODD));
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          // Returning to IDLE at mid stop bit leaves half a bit to catch a back-to-back start edge.
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          if (!rxd_s_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_mis_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD       = 115200;
  localparam int BAUD_DIV   = CLK_FREQ / BAUD;
  localparam int PARITY_ODD = 0;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_data = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic       tx_par_flip = 1'b0;
`endif

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #10 sys_clk = ~sys_clk;

  // Output monitor on the falling edge
  int         cyc = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0;
  int         n_overlap = 0, n_wide = 0, busy_cycles = 0;
  int         last_valid_cyc = -1, last_busy_fall_cyc = -100;
  logic       prev_pulse = 1'b0, prev_busy = 1'b0;
  logic [7:0] obs_q[$];

  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (rx_valid) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
      obs_q.push_back(rx_data);
    end
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if ((int'(rx_valid) + int'(frame_err) + int'(parity_err)) > 1) n_overlap <= n_overlap + 1;
    if (prev_pulse && (rx_valid || frame_err || parity_err)) n_wide <= n_wide + 1;
    prev_pulse <= rx_valid | frame_err | parity_err;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (prev_busy && !busy) last_busy_fall_cyc <= cyc;
    prev_busy <= busy;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drives one frame; leaves the line at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    uart_rxd = 1'b0;
    wait_cycles(BAUD_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      wait_cycles(BAUD_DIV);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ (PARITY_ODD != 0) ^ tx_par_flip;
    wait_cycles(BAUD_DIV);
`endif
    uart_rxd = stop_b;
    wait_cycles(BAUD_DIV);
  endtask

  task automatic test_reset();
    sys_rst  = 1'b1;
    uart_rxd = 1'b1;
    wait_cycles(5);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    sys_rst = 1'b0;
    wait_cycles(5);
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_byte();
    int v0, f0, o0, dly;
    v0 = n_valid; f0 = n_ferr; o0 = obs_q.size();
    send_frame(8'h55, 1'b1);
    wait_cycles(20);
    model_data = 8'h55;
    n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d expected 1", n_valid - v0); end
    n_tests++;
    if (obs_q.size() <= o0) begin n_fail++; $display("FAIL single_data: got no byte expected 55"); end
    else if (obs_q[o0] !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h expected 55", obs_q[o0]); end
    n_tests++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", n_ferr - f0); end
    n_tests++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL single_rx_data: got %h expected 55", rx_data); end
    dly = last_busy_fall_cyc - last_valid_cyc;
    n_tests++; if (dly < -1 || dly > 1) begin n_fail++; $display("FAIL single_busy_fall: got offset %0d expected -1..1", dly); end
  endtask

  task automatic test_glitch();
    int v0, f0, b0, bc;
    v0 = n_valid; f0 = n_ferr; b0 = busy_cycles;
    uart_rxd = 1'b0;
    wait_cycles(100);
    uart_rxd = 1'b1;
    wait_cycles(600);
    bc = busy_cycles - b0;
    n_tests++; if (bc < 214 || bc > 220) begin n_fail++; $display("FAIL glitch_busy_len: got %0d expected about 217", bc); end
    n_tests++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", n_valid - v0); end
    n_tests++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", n_ferr - f0); end
    n_tests++; if (rx_data !== model_data) begin n_fail++; $display("FAIL glitch_rx_data: got %h expected %h", rx_data, model_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_frame_error_break();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA3, 1'b0);
    wait_cycles(3 * BAUD_DIV);
    uart_rxd = 1'b1;
    wait_cycles(100);
    n_tests++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
    n_tests++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected 0", n_valid - v0); end
    n_tests++; if (rx_data !== model_data) begin n_fail++; $display("FAIL ferr_rx_data: got %h expected %h", rx_data, model_data); end
  endtask

  task automatic test_back_to_back();
    int v0, f0, o0;
    v0 = n_valid; f0 = n_ferr; o0 = obs_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cycles(20);
    model_data = 8'hFF;
    n_tests++; if (n_valid - v0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", n_valid - v0); end
    n_tests++;
    if (obs_q.size() < o0 + 2) begin n_fail++; $display("FAIL b2b_data: got %0d bytes expected 2", obs_q.size() - o0); end
    else if (obs_q[o0] !== 8'h00 || obs_q[o0+1] !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_data: got %h %h expected 00 ff", obs_q[o0], obs_q[o0+1]);
    end
    n_tests++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d expected 0", n_ferr - f0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int v0, o0;
    d = 8'h3C;
    uart_rxd = 1'b0;
    wait_cycles(BAUD_DIV);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = d[i];
      wait_cycles(BAUD_DIV);
    end
    uart_rxd = d[4];
    wait_cycles(BAUD_DIV / 2);
    sys_rst = 1'b1;
    wait_cycles(2);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rx_data: got %h expected 00", rx_data); end
    uart_rxd = 1'b1;
    wait_cycles(3);
    sys_rst = 1'b0;
    model_data = 8'h00;
    wait_cycles(BAUD_DIV);
    v0 = n_valid; o0 = obs_q.size();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_after_busy: got %b expected 0", busy); end
    send_frame(8'hC3, 1'b1);
    wait_cycles(20);
    model_data = 8'hC3;
    n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL rst_after_count: got %0d expected 1", n_valid - v0); end
    n_tests++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL rst_after_data: got %h expected c3", rx_data); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       stop_b, flip;
    int v0, f0, p0, o0, exp_ferr, exp_perr;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; o0 = obs_q.size();
    exp_ferr = 0; exp_perr = 0;
    for (int k = 0; k < 6; k++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      flip   = 1'b0;
`ifdef UART_RX_PARITY_EN
      flip        = ($urandom_range(0, 3) == 0);
      tx_par_flip = flip;
`endif
      if (!stop_b) exp_ferr++;
      else if (flip) exp_perr++;
      else begin exp_q.push_back(d); model_data = d; end
      send_frame(d, stop_b);
      uart_rxd = 1'b1;
      wait_cycles($urandom_range(10, 200));
    end
`ifdef UART_RX_PARITY_EN
    tx_par_flip = 1'b0;
`endif
    n_tests++; if (n_valid - v0 !== exp_q.size()) begin n_fail++; $display("FAIL rand_valid_count: got %0d expected %0d", n_valid - v0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q.size() <= o0 + i) begin n_fail++; $display("FAIL rand_data[%0d]: got none expected %h", i, exp_q[i]); end
      else if (obs_q[o0+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, obs_q[o0+i], exp_q[i]); end
    end
    n_tests++; if (n_ferr - f0 !== exp_ferr) begin n_fail++; $display("FAIL rand_frame_err: got %0d expected %0d", n_ferr - f0, exp_ferr); end
    n_tests++; if (n_perr - p0 !== exp_perr) begin n_fail++; $display("FAIL rand_parity_err: got %0d expected %0d", n_perr - p0, exp_perr); end
    n_tests++; if (rx_data !== model_data) begin n_fail++; $display("FAIL rand_rx_data: got %h expected %h", rx_data, model_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0, o0;
    v0 = n_valid; p0 = n_perr; o0 = obs_q.size();
    tx_par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    wait_cycles(20);
    model_data = 8'h07;
    n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL par_good_valid: got %0d expected 1", n_valid - v0); end
    n_tests++;
    if (obs_q.size() <= o0) begin n_fail++; $display("FAIL par_good_data: got none expected 07"); end
    else if (obs_q[o0] !== 8'h07) begin n_fail++; $display("FAIL par_good_data: got %h expected 07", obs_q[o0]); end
    n_tests++; if (n_perr - p0 !== 0) begin n_fail++; $display("FAIL par_good_perr: got %0d expected 0", n_perr - p0); end
    v0 = n_valid; p0 = n_perr;
    tx_par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tx_par_flip = 1'b0;
    wait_cycles(20);
    n_tests++; if (n_perr - p0 !== 1) begin n_fail++; $display("FAIL par_bad_perr: got %0d expected 1", n_perr - p0); end
    n_tests++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL par_bad_valid: got %0d expected 0", n_valid - v0); end
  endtask
`endif

  task automatic test_pulse_shape();
    n_tests++; if (n_overlap !== 0) begin n_fail++; $display("FAIL pulse_overlap: got %0d expected 0", n_overlap); end
    n_tests++; if (n_wide !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d expected 0", n_wide); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error_break();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_pulse_shape();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
